// File: rtl/dsp_reset_sequencer.sv
// dsp_reset_sequencer: sequences C6678 POR#/RESETFULL#/RESET# and arbitrates reset requests
//   clk, rst_n      : clock, asynchronous active-low reset (output of the FPGA reset generator)
//   pwr_good        : DSP rails good; loss aborts any sequence and holds all pins low
//   hw/sw_full_req  : full (POR) reset requests; hw has priority over sw
//   hw/sw_warm_req  : warm (RESET# only) requests; honoured only in RUN
//   resetstat_n     : DSP RESETSTAT#, awaited after the pins are released
//   dsp_*_n         : registered DSP reset pins
//   seq_busy/done   : busy outside RUN; one-cycle pulse on RUN entry
//   timeout_err     : sticky RESETSTAT# timeout, cleared on POR entry
//   last_cause      : 1 power-on, 2/3 hw/sw full, 4/5 hw/sw warm
module dsp_reset_sequencer #(
    parameter logic [19:0] POR_DELAY    = 20'd50000,
    parameter logic [19:0] FULL_DELAY   = 20'd10000,
    parameter logic [19:0] WARM_DELAY   = 20'd1000,
    parameter logic [19:0] STAT_TIMEOUT = 20'd200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_good,
    input  logic       hw_full_req,
    input  logic       hw_warm_req,
    input  logic       sw_full_req,
    input  logic       sw_warm_req,
    input  logic       resetstat_n,
    output logic       dsp_por_n,
    output logic       dsp_resetfull_n,
    output logic       dsp_reset_n,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       timeout_err,
    output logic [2:0] last_cause
);
    typedef enum logic [2:0] {OFF, POR, FULL, STAT, RUN, WARM} state_t;
    state_t state, nxt;
    logic [19:0] cnt;
    logic restart, nxt_terr;
    logic [2:0] nxt_cause;
    always_comb begin
        nxt = state;
        restart = 1'b0;
        nxt_terr = timeout_err;
        nxt_cause = last_cause;
        case (state)
            OFF: if (pwr_good) begin
                nxt = POR;
                nxt_cause = 3'd1;
            end
            POR: nxt = (cnt == POR_DELAY - 20'd1) ? FULL : POR;
            FULL: nxt = (cnt == FULL_DELAY - 20'd1) ? STAT : FULL;
            STAT: if (resetstat_n) nxt = RUN;
                else if (cnt == STAT_TIMEOUT - 20'd1) begin
                    nxt = RUN;
                    nxt_terr = 1'b1;
                end
            RUN: if (hw_warm_req || sw_warm_req) begin
                nxt = WARM;
                nxt_cause = hw_warm_req ? 3'd4 : 3'd5;
            end
            WARM: nxt = (cnt == WARM_DELAY - 20'd1) ? STAT : WARM;
            default: nxt = OFF;
        endcase
        // Power loss and full requests override whatever the state logic chose.
        if (state != OFF) begin
            if (!pwr_good) nxt = OFF;
            else if (hw_full_req || sw_full_req) begin
                nxt = POR;
                restart = 1'b1;
                nxt_cause = hw_full_req ? 3'd2 : 3'd3;
            end
        end
        if (nxt == POR && (state != POR || restart)) nxt_terr = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            cnt <= '0;
            dsp_por_n <= 1'b0;
            dsp_resetfull_n <= 1'b0;
            dsp_reset_n <= 1'b0;
            seq_busy <= 1'b1;
            seq_done <= 1'b0;
            timeout_err <= 1'b0;
            last_cause <= 3'd0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state || restart) ? '0 : cnt + 20'd1;
            dsp_por_n <= nxt != OFF && nxt != POR;
            dsp_resetfull_n <= nxt == STAT || nxt == RUN || nxt == WARM;
            dsp_reset_n <= nxt == STAT || nxt == RUN;
            seq_busy <= nxt != RUN;
            seq_done <= nxt == RUN && state != RUN;
            timeout_err <= nxt_terr;
            last_cause <= nxt_cause;
        end
    end
endmodule

// File: tb/tb_dsp_reset_sequencer.sv
// tb_dsp_reset_sequencer: directed scenarios plus random stimulus against a schedule-based model
module tb_dsp_reset_sequencer;
    localparam int P = 8, F = 4, W = 3, T = 10;
    localparam int M_OFF = 0, M_FULL = 1, M_WARM = 2, M_RUN = 3;
    logic clk = 1'b0, rst_n = 1'b1, pwr_good = 1'b1;
    logic hw_full_req = 1'b0, hw_warm_req = 1'b0, sw_full_req = 1'b0, sw_warm_req = 1'b0;
    logic resetstat_n = 1'b0;
    logic dsp_por_n, dsp_resetfull_n, dsp_reset_n, seq_busy, seq_done, timeout_err;
    logic [2:0] last_cause;
    int n_checks = 0, n_fail = 0;
    int m_mode, m_e, m_cause;
    logic m_terr, m_done;

    dsp_reset_sequencer #(
        .POR_DELAY(20'd8), .FULL_DELAY(20'd4), .WARM_DELAY(20'd3), .STAT_TIMEOUT(20'd10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwr_good(pwr_good),
        .hw_full_req(hw_full_req), .hw_warm_req(hw_warm_req),
        .sw_full_req(sw_full_req), .sw_warm_req(sw_warm_req),
        .resetstat_n(resetstat_n), .dsp_por_n(dsp_por_n),
        .dsp_resetfull_n(dsp_resetfull_n), .dsp_reset_n(dsp_reset_n),
        .seq_busy(seq_busy), .seq_done(seq_done), .timeout_err(timeout_err),
        .last_cause(last_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Pins follow from elapsed time inside the current sequence.
    function automatic logic [2:0] exp_pins();
        if (m_mode == M_OFF) return 3'b000;
        if (m_mode == M_RUN) return 3'b111;
        if (m_mode == M_WARM) return (m_e < W) ? 3'b110 : 3'b111;
        if (m_e < P) return 3'b000;
        return (m_e < P + F) ? 3'b100 : 3'b111;
    endfunction

    task automatic mreset();
        m_mode = M_OFF; m_e = 0; m_cause = 0; m_terr = 1'b0; m_done = 1'b0;
    endtask

    task automatic start_full(input int cause);
        m_mode = M_FULL; m_e = 0; m_cause = cause; m_terr = 1'b0;
    endtask

    task automatic mstep();
        int stat_start;
        m_done = 1'b0;
        if (m_mode == M_OFF) begin
            if (pwr_good) start_full(1);
        end else if (!pwr_good) m_mode = M_OFF;
        else if (hw_full_req || sw_full_req) start_full(hw_full_req ? 2 : 3);
        else if (m_mode == M_RUN) begin
            if (hw_warm_req || sw_warm_req) begin
                m_mode = M_WARM; m_e = 0; m_cause = hw_warm_req ? 4 : 5;
            end
        end else begin
            stat_start = (m_mode == M_FULL) ? P + F : W;
            if (m_e >= stat_start && (resetstat_n || m_e - stat_start == T - 1)) begin
                if (!resetstat_n) m_terr = 1'b1;
                m_mode = M_RUN; m_done = 1'b1;
            end else m_e++;
        end
    endtask

    task automatic compare();
        logic [2:0] ep;
        ep = exp_pins();
        chk("por_n", dsp_por_n, ep[2]);
        chk("resetfull_n", dsp_resetfull_n, ep[1]);
        chk("reset_n", dsp_reset_n, ep[0]);
        chk("seq_busy", seq_busy, m_mode != M_RUN);
        chk("seq_done", seq_done, m_done);
        chk("timeout_err", timeout_err, m_terr);
        chk("last_cause", last_cause, m_cause);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) mreset(); else mstep();
        #1;
        compare();
    endtask

    task automatic run_until_run(input int lim);
        for (int i = 0; i < lim && m_mode != M_RUN; i++) tick();
        chk("reach_run", seq_busy, 1'b0);
    endtask

    task automatic wait_full_phase(input int lim);
        for (int i = 0; i < lim && !(m_mode == M_FULL && m_e >= P && m_e < P + F - 1); i++) tick();
        chk("reach_full", {dsp_por_n, dsp_resetfull_n}, 2'b10);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pins"}, {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b000);
        chk({tag, "_busy"}, seq_busy, 1'b1);
        chk({tag, "_done"}, seq_done, 1'b0);
        chk({tag, "_terr"}, timeout_err, 1'b0);
        chk({tag, "_cause"}, last_cause, 3'd0);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_pulse();
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        mreset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse(input int which);
        case (which)
            0: hw_full_req = 1'b1;
            1: sw_full_req = 1'b1;
            2: hw_warm_req = 1'b1;
            default: sw_warm_req = 1'b1;
        endcase
        tick();
        {hw_full_req, sw_full_req, hw_warm_req, sw_warm_req} = '0;
    endtask

    initial begin
        mreset();
        #1 rst_n = 1'b0;
        #2 check_reset_vals("rst_async");
        tick();
        tick();
        check_reset_vals("rst_hold");
        // Power-on with RESETSTAT# rising two cycles into STAT.
        rst_n = 1'b1;
        for (int i = 0; i < 1 + P + F; i++) tick();
        chk("t1_stat_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b111);
        tick();
        resetstat_n = 1'b1;
        tick();
        chk("t1_done", seq_done, 1'b1);
        chk("t1_cause", last_cause, 3'd1);
        tick();
        chk("t1_done_once", seq_done, 1'b0);
        // Warm reset from software.
        pulse(3);
        chk("t2_warm_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b110);
        tick();
        tick();
        chk("t2_still_low", dsp_reset_n, 1'b0);
        tick();
        chk("t2_released", dsp_reset_n, 1'b1);
        tick();
        chk("t2_done", seq_done, 1'b1);
        chk("t2_cause", last_cause, 3'd5);
        // RESETSTAT# timeout, then cleared by a hardware full reset.
        resetstat_n = 1'b0;
        pulse(2);
        for (int i = 0; i < W + T - 1; i++) tick();
        chk("t3_not_yet", seq_busy, 1'b1);
        tick();
        chk("t3_terr", timeout_err, 1'b1);
        chk("t3_run", seq_busy, 1'b0);
        pulse(0);
        chk("t3_terr_clr", timeout_err, 1'b0);
        chk("t3_cause", last_cause, 3'd2);
        resetstat_n = 1'b1;
        run_until_run(40);
        // Preemption of WARM and hw/sw full priority.
        pulse(3);
        tick();
        pulse(1);
        chk("t4_preempt", last_cause, 3'd3);
        chk("t4_por", dsp_por_n, 1'b0);
        hw_full_req = 1'b1;
        pulse(1);
        chk("t4_hw_wins", last_cause, 3'd2);
        wait_full_phase(20);
        hw_warm_req = 1'b1;
        tick();
        tick();
        hw_warm_req = 1'b0;
        run_until_run(20);
        chk("t4_warm_dropped", last_cause, 3'd2);
        // Power loss mid-FULL.
        pulse(0);
        wait_full_phase(20);
        pwr_good = 1'b0;
        tick();
        chk("t5_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b000);
        chk("t5_busy", seq_busy, 1'b1);
        tick();
        chk("t5_no_done", seq_done, 1'b0);
        pwr_good = 1'b1;
        run_until_run(40);
        chk("t5_cause", last_cause, 3'd1);
        // Asynchronous reset in the middle of STAT.
        resetstat_n = 1'b0;
        pulse(1);
        for (int i = 0; i < P + F + 2; i++) tick();
        async_pulse();
        resetstat_n = 1'b1;
        run_until_run(40);
        chk("t6_cause", last_cause, 3'd1);
        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 2) pwr_good = ~pwr_good;
            if (!pwr_good && $urandom_range(9) < 3) pwr_good = 1'b1;
            hw_full_req = $urandom_range(99) < 2;
            sw_full_req = $urandom_range(99) < 2;
            sw_warm_req = $urandom_range(99) < 5;
            if ($urandom_range(99) < 4) hw_warm_req = ~hw_warm_req;
            resetstat_n = $urandom_range(3) == 0;
            if ($urandom_range(999) < 3) async_pulse();
            else tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dsp_reset_sequencer.md
Name: dsp_reset_sequencer

Overview:
- Sequences the C6678 DSP reset pins (POR#, RESETFULL#, RESET#) after the FPGA's internal reset is released.
- Arbitrates reset requests from power-good loss, hardware full/warm sources and software full/warm register pulses.
- Sits directly downstream of the FPGA internal reset generator; its rst_n is that generator's output.
- Confirms DSP reset completion via RESETSTAT# with a timeout.

Parameters:
- POR_DELAY, 20'd50000: cycles POR#, RESETFULL# and RESET# are all held asserted.
- FULL_DELAY, 20'd10000: cycles RESETFULL# stays asserted after POR# release.
- WARM_DELAY, 20'd1000: cycles RESET# is held asserted for a warm reset.
- STAT_TIMEOUT, 20'd200000: maximum cycles to wait for resetstat_n high.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- pwr_good  input  1  DSP rails good; synchronous to clk, level
- hw_full_req  input  1  hardware full-reset request; synchronous, level or pulse
- hw_warm_req  input  1  hardware warm-reset request; synchronous, level or pulse
- sw_full_req  input  1  software full-reset request; one-cycle pulse
- sw_warm_req  input  1  software warm-reset request; one-cycle pulse
- resetstat_n  input  1  DSP RESETSTAT#; low while DSP is in reset; synchronous
- dsp_por_n  output  1  DSP POR#
- dsp_resetfull_n  output  1  DSP RESETFULL#
- dsp_reset_n  output  1  DSP RESET#
- seq_busy  output  1  high in every state except RUN
- seq_done  output  1  one-cycle pulse on entry to RUN
- timeout_err  output  1  sticky: RESETSTAT# wait expired
- last_cause  output  3  cause of the most recent sequence

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; the clock is clk. All state updates on posedge clk.
- Values while rst_n is low:
  - state OFF
  - dsp_por_n, dsp_resetfull_n, dsp_reset_n = 0
  - seq_busy = 1, seq_done = 0, timeout_err = 0, last_cause = 3'd0
  - counter = 0
- Outputs are registered. The pin values listed per state apply from the first cycle after the transition.
- Counter: 20-bit. Cleared on every state transition, otherwise increments. "Held N cycles" means exit on the cycle where counter == N-1.
- States:
  - OFF: pins 0/0/0. Go to POR when pwr_good = 1. Set last_cause = 1 (power-on).
  - POR: pins 0/0/0. After POR_DELAY cycles, go to FULL.
  - FULL: pins 1/0/0. After FULL_DELAY cycles, go to STAT.
  - STAT: pins 1/1/1.
    - resetstat_n = 1: go to RUN.
    - counter reaches STAT_TIMEOUT-1 with resetstat_n still 0: set timeout_err, go to RUN anyway.
  - RUN: pins 1/1/1. Accept requests.
  - WARM: pins 1/1/0. After WARM_DELAY cycles, go to STAT.
- Priority (highest first), evaluated every cycle in every state except OFF:
  1. pwr_good = 0: go to OFF immediately, all pins 0. This aborts any sequence.
  2. Full request (hw_full_req or sw_full_req): go to POR. Set last_cause to 2 (hw) or 3 (sw); hw wins if both are asserted.
  3. Warm request, accepted only in RUN: go to WARM. Set last_cause to 4 (hw) or 5 (sw); hw wins.
- A full request while already in POR restarts the POR count and updates last_cause.
- A full request preempts WARM, FULL and STAT.
- Warm requests outside RUN are dropped, not queued.
- A level-held hw_warm_req re-triggers WARM on each return to RUN.
- A level-held hw_full_req keeps the block in POR.
- timeout_err clears on entry to POR (any cause). It does not clear on a warm sequence.
- seq_done pulses exactly once per completed sequence. It does not pulse when a sequence is aborted.
- Re-assertion of rst_n mid-sequence forces the reset values immediately (asynchronous).

Test Plan:
Parameters for all scenarios: POR_DELAY=8, FULL_DELAY=4, WARM_DELAY=3, STAT_TIMEOUT=10.
1. Power-on: rst_n release with pwr_good=1 and resetstat_n rising 2 cycles after STAT entry -> dsp_por_n low 8 cycles, then dsp_resetfull_n low 4 more, then dsp_reset_n high; seq_done pulses once; last_cause=1; timeout_err=0.
2. Warm in RUN: sw_warm_req pulse, resetstat_n held high -> dsp_reset_n low exactly 3 cycles, other pins stay 1; last_cause=5; seq_done pulse.
3. Timeout: resetstat_n held 0 -> RUN entered 10 cycles after STAT entry with timeout_err=1; a following hw_full_req clears timeout_err on POR entry; last_cause=2.
4. Preemption and priority: sw_full_req 1 cycle into WARM -> POR entered, last_cause=3. hw_full_req and sw_full_req in the same cycle -> last_cause=2. hw_warm_req during FULL -> ignored.
5. Power loss: pwr_good=0 mid-FULL -> all pins 0 next cycle, seq_busy=1, no seq_done. pwr_good=1 -> full POR sequence restarts, last_cause=1.
6. Async reset: rst_n pulsed low for 1 cycle mid-STAT -> all outputs at reset values without a clock edge; full sequence repeats after release.
